jamma_input_scanner: RTL and testbench

Upstream input stage for the arcade cores on the JAMMA adapter. It replaces the free-running single-cycle JSELECT toggle with a timed scan. Each phase waits for the external multiplexer to settle, then samples both player banks, debounces every button, merges the local 6-bit joystick into player 1, and shapes the coin inputs into fixed-width pulses. Its outputs feed the core's I_JOYSTICK_A/B, I_PLAYER and I_COIN directly. All inputs and outputs are active-low (1 = released).

---
 rtl/jamma_input_scanner.sv | 171 +++++++++++++++++
 tb/tb_jamma_input_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jamma_input_scanner.sv
// rtl/jamma_input_scanner.sv - timed JAMMA bank scanner with per-bit debounce and coin pulse shaping
// Alternates JSELECT between players, samples each bank after the mux settles.
module jamma_input_scanner #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int DEBOUNCE_COUNT = 3,
   parameter int COIN_PULSE     = 16
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic [7:0] JJOY,
   input  logic [5:0] JOYSTICK,
   input  logic [1:0] JCOIN,
   output logic       JSELECT,
   output logic [7:0] joystick1,
   output logic [7:0] joystick2,
   output logic [1:0] coin_out,
   output logic       scan_done
);

   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0]  DB_LAST     = 4'(DEBOUNCE_COUNT - 1);
   localparam logic [15:0] PULSE_LEN   = 16'(COIN_PULSE);

   typedef enum logic [1:0] {
      P1_SETTLE = 2'b00,
      P1_SAMPLE = 2'b01,
      P2_SETTLE = 2'b10,
      P2_SAMPLE = 2'b11
   } state_t;

   // Reset asserts immediately but releases only after two clean clock edges.
   logic rst_meta_q;
   logic rst_sync_q;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   state_t     state_q, state_d;
   logic [7:0] settle_q, settle_d;
   logic       jsel_q, jsel_d;
   logic       cap_p1, cap_p2;

   always_ff @(posedge pclk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q  <= P1_SETTLE;
         settle_q <= 8'd0;
         jsel_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         jsel_q   <= jsel_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         P1_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = 8'd0;
               state_d  = P1_SAMPLE;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         P1_SAMPLE: state_d = P2_SETTLE;
         P2_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = 8'd0;
               state_d  = P2_SAMPLE;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         P2_SAMPLE: state_d = P1_SETTLE;
         default:   state_d = P1_SETTLE;
      endcase
   end

   // Select follows the state being entered, so it is stable through every sample cycle.
   always_comb begin
      jsel_d    = (state_d == P2_SETTLE) || (state_d == P2_SAMPLE);
      cap_p1    = (state_q == P1_SAMPLE);
      cap_p2    = (state_q == P2_SAMPLE);
      scan_done = cap_p2;
   end

   assign JSELECT = jsel_q;

   logic [15:0] db_sample;
   logic [15:0] db_en;
   logic [15:0] db_out_q, db_out_d;
   logic [3:0]  db_cnt_q [16];
   logic [3:0]  db_cnt_d [16];

   assign db_sample = {JJOY, JJOY & {2'b11, JOYSTICK}};
   assign db_en     = {{8{cap_p2}}, {8{cap_p1}}};

   always_comb begin
      db_out_d = db_out_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 16; i++) begin
         if (db_en[i]) begin
            if (db_sample[i] == db_out_q[i]) begin
               db_cnt_d[i] = 4'd0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               db_out_d[i] = db_sample[i];
               db_cnt_d[i] = 4'd0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         db_out_q <= 16'hFFFF;
         db_cnt_q <= '{default: 4'd0};
      end else begin
         db_out_q <= db_out_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign joystick1 = db_out_q[7:0];
   assign joystick2 = db_out_q[15:8];

   // Third flop only provides the previous value for edge detection.
   logic [1:0]       coin_s1_q, coin_s2_q, coin_s3_q;
   logic [1:0]       coin_fall;
   logic [1:0][15:0] coin_cnt_q, coin_cnt_d;

   assign coin_fall = coin_s3_q & ~coin_s2_q;

   always_comb begin
      coin_cnt_d = coin_cnt_q;
      coin_out   = 2'b11;
      for (int i = 0; i < 2; i++) begin
         if (coin_cnt_q[i] != 16'd0) begin
            coin_cnt_d[i] = coin_cnt_q[i] - 16'd1;
         end else if (coin_fall[i]) begin
            coin_cnt_d[i] = PULSE_LEN;
         end
         coin_out[i] = (coin_cnt_q[i] == 16'd0);
      end
   end

   always_ff @(posedge pclk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         coin_s1_q  <= 2'b11;
         coin_s2_q  <= 2'b11;
         coin_s3_q  <= 2'b11;
         coin_cnt_q <= '0;
      end else begin
         coin_s1_q  <= JCOIN;
         coin_s2_q  <= coin_s1_q;
         coin_s3_q  <= coin_s2_q;
         coin_cnt_q <= coin_cnt_d;
      end
   end

endmodule

// File: tb/tb_jamma_input_scanner.sv
// tb/tb_jamma_input_scanner.sv - scoreboard bench for jamma_input_scanner
// Emulates the external bank mux and predicts debounced outputs per scan.
module tb_jamma_input_scanner;

   localparam int SETTLE = 4;
   localparam int DEB    = 3;
   localparam int PULSE  = 16;

   logic       pclk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] p1_bank = 8'hFF;
   logic [7:0] p2_bank = 8'hFF;
   logic [5:0] joy = 6'h3F;
   logic [1:0] jcoin = 2'b11;
   logic [7:0] JJOY;
   logic       JSELECT;
   logic [7:0] j1, j2;
   logic [1:0] coin;
   logic       scan_done;

   assign JJOY = JSELECT ? p2_bank : p1_bank;

   jamma_input_scanner #(
      .SETTLE_CYCLES (SETTLE),
      .DEBOUNCE_COUNT(DEB),
      .COIN_PULSE    (PULSE)
   ) dut (
      .pclk     (pclk),
      .rst_n    (rst_n),
      .JJOY     (JJOY),
      .JOYSTICK (joy),
      .JCOIN    (jcoin),
      .JSELECT  (JSELECT),
      .joystick1(j1),
      .joystick2(j2),
      .coin_out (coin),
      .scan_done(scan_done)
   );

   always #5 pclk = ~pclk;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] sb_q[$];
   logic [7:0]  m_j1, m_j2;
   int          m_run[16];

   task automatic model_reset();
      m_j1 = 8'hFF;
      m_j2 = 8'hFF;
      for (int b = 0; b < 16; b++) m_run[b] = 0;
      sb_q.delete();
   endtask

   task automatic model_scan(input logic [7:0] s1, input logic [7:0] s2);
      logic [15:0] s, o;
      s = {s2, s1};
      o = {m_j2, m_j1};
      for (int b = 0; b < 16; b++) begin
         if (s[b] !== o[b]) begin
            m_run[b]++;
            if (m_run[b] >= DEB) begin
               o[b] = s[b];
               m_run[b] = 0;
            end
         end else begin
            m_run[b] = 0;
         end
      end
      m_j1 = o[7:0];
      m_j2 = o[15:8];
   endtask

   task automatic wait_scan_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge pclk);
         if (scan_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Called in the first P1_SETTLE cycle so both banks are stable before their sample.
   task automatic run_scan(input logic [7:0] p1, input logic [7:0] p2, input logic [5:0] js, input string tag);
      bit          ok;
      logic [15:0] exp;
      p1_bank = p1;
      p2_bank = p2;
      joy     = js;
      model_scan(p1 & {2'b11, js}, p2);
      sb_q.push_back({m_j2, m_j1});
      wait_scan_done(ok);
      @(negedge pclk);
      exp = sb_q.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s scan_done timeout", tag);
      end else if ({j2, j1} !== exp) begin
         n_fail++;
         $display("FAIL %s joystick2/joystick1 got %h/%h expected %h/%h", tag, j2, j1, exp[15:8], exp[7:0]);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks++;
      if (JSELECT !== 1'b0) begin n_fail++; $display("FAIL %s JSELECT got %b expected 0", tag, JSELECT); end
      n_checks++;
      if (j1 !== 8'hFF) begin n_fail++; $display("FAIL %s joystick1 got %h expected ff", tag, j1); end
      n_checks++;
      if (j2 !== 8'hFF) begin n_fail++; $display("FAIL %s joystick2 got %h expected ff", tag, j2); end
      n_checks++;
      if (coin !== 2'b11) begin n_fail++; $display("FAIL %s coin_out got %b expected 11", tag, coin); end
      n_checks++;
      if (scan_done !== 1'b0) begin n_fail++; $display("FAIL %s scan_done got %b expected 0", tag, scan_done); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge pclk);
      check_reset_outputs("reset");
   endtask

   task automatic test_idle_scan();
      int   cyc;
      logic ej, es;
      rst_n = 1'b1;
      cyc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge pclk);
         cyc++;
         if (scan_done === 1'b1) break;
      end
      n_checks++;
      if (cyc != 11) begin n_fail++; $display("FAIL idle_first_scan_done cycle got %0d expected 11", cyc); end
      for (int k = 1; k <= 20; k++) begin
         @(negedge pclk);
         ej = (((k - 1) % 10) >= 5);
         es = (k == 10 || k == 20);
         n_checks++;
         if (JSELECT !== ej) begin n_fail++; $display("FAIL idle_jselect k=%0d got %b expected %b", k, JSELECT, ej); end
         n_checks++;
         if (scan_done !== es) begin n_fail++; $display("FAIL idle_scan_done k=%0d got %b expected %b", k, scan_done, es); end
      end
      n_checks++;
      if ({j1, j2, coin} !== {8'hFF, 8'hFF, 2'b11}) begin
         n_fail++;
         $display("FAIL idle_outputs got %h %h %b expected ff ff 11", j1, j2, coin);
      end
      @(negedge pclk);
   endtask

   task automatic test_p1_press();
      for (int s = 0; s < 4; s++) run_scan(8'hFE, 8'hFF, 6'h3F, "p1_press");
   endtask

   task automatic test_p2_glitch();
      for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'hFF, 6'h3F, "p1_release");
      for (int s = 0; s < 2; s++) run_scan(8'hFF, 8'h7F, 6'h3F, "p2_glitch");
      for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'hFF, 6'h3F, "p2_glitch_gone");
      for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'h7F, 6'h3F, "p2_hold");
      for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'hFF, 6'h3F, "p2_release");
   endtask

   task automatic test_local_joystick();
      for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'hFF, 6'h3D, "local_joy");
      for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'hFF, 6'h3F, "local_joy_release");
   endtask

   task automatic test_coin();
      logic       e0;
      logic [1:0] eb;
      jcoin[0] = 1'b0;
      for (int i = 1; i <= 130; i++) begin
         @(negedge pclk);
         e0 = !(i >= 3 && i <= 18);
         n_checks++;
         if (coin[0] !== e0) begin n_fail++; $display("FAIL coin0_pulse i=%0d got %b expected %b", i, coin[0], e0); end
         n_checks++;
         if (coin[1] !== 1'b1) begin n_fail++; $display("FAIL coin1_idle i=%0d got %b expected 1", i, coin[1]); end
         if (i == 10) jcoin[0] = 1'b1;
         if (i == 11) jcoin[0] = 1'b0;
         if (i == 100) jcoin[0] = 1'b1;
      end
      jcoin = 2'b00;
      for (int i = 1; i <= 22; i++) begin
         @(negedge pclk);
         eb = (i >= 3 && i <= 18) ? 2'b00 : 2'b11;
         n_checks++;
         if (coin !== eb) begin n_fail++; $display("FAIL coin_both i=%0d got %b expected %b", i, coin, eb); end
      end
      jcoin = 2'b11;
      repeat (4) @(negedge pclk);
   endtask

   task automatic test_reset_mid();
      bit   ok;
      logic ej, es;
      wait_scan_done(ok);
      @(negedge pclk);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL reset_mid_align scan_done timeout"); end
      for (int s = 0; s < 3; s++) run_scan(8'hFE, 8'hFF, 6'h3F, "pre_reset");
      jcoin[1] = 1'b0;
      repeat (6) @(negedge pclk);
      n_checks++;
      if (JSELECT !== 1'b1) begin n_fail++; $display("FAIL reset_mid_in_p2 JSELECT got %b expected 1", JSELECT); end
      n_checks++;
      if (coin[1] !== 1'b0) begin n_fail++; $display("FAIL reset_mid_coin_active got %b expected 0", coin[1]); end
      @(posedge pclk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_async");
      jcoin   = 2'b11;
      p1_bank = 8'hFF;
      model_reset();
      @(negedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
      for (int cyc = 1; cyc <= 11; cyc++) begin
         @(negedge pclk);
         ej = (cyc >= 7);
         es = (cyc == 11);
         n_checks++;
         if (JSELECT !== ej) begin n_fail++; $display("FAIL restart_jselect cyc=%0d got %b expected %b", cyc, JSELECT, ej); end
         n_checks++;
         if (scan_done !== es) begin n_fail++; $display("FAIL restart_scan_done cyc=%0d got %b expected %b", cyc, scan_done, es); end
      end
      @(negedge pclk);
      for (int s = 0; s < 3; s++) run_scan(8'hFE, 8'hFF, 6'h3F, "post_reset");
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_p1_press();
      test_p2_glitch();
      test_local_joystick();
      test_coin();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
